// File: rtl/bsg_blackparrot_pkg.sv
// Shared BlackParrot/manycore link definitions: scheduler FSM states and default link count.
package bsg_blackparrot_pkg;

  localparam int bp_mc_num_links_gp = 3;

  typedef enum logic [1:0] {
    e_run   = 2'd0,
    e_drain = 2'd1,
    e_done  = 2'd2
  } bp_mc_sched_state_e;

endpackage

// File: rtl/bsg_blackparrot_mc_credit_counter.sv
// Per-link outstanding-request counter: reservation increments, returned credits decrement,
// a credit arriving at zero is dropped and latches a sticky error.
module bsg_blackparrot_mc_credit_counter #(
  parameter int max_out_p   = 8,
  parameter int cnt_width_p = $clog2(max_out_p + 1)
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic                   inc_i,
  input  logic                   dec_i,
  output logic [cnt_width_p-1:0] cnt_o,
  output logic                   max_o,
  output logic                   zero_o,
  output logic                   err_o
);

  logic [cnt_width_p-1:0] cnt_r;
  logic                   err_r;
  logic                   dec_ok;

  assign zero_o = (cnt_r == '0);
  assign max_o  = (cnt_r == cnt_width_p'(max_out_p));
  assign dec_ok = dec_i & ~zero_o;
  assign cnt_o  = cnt_r;
  assign err_o  = err_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_r <= '0;
      err_r <= 1'b0;
    end else begin
      if (dec_i & zero_o)
        err_r <= 1'b1;
      if (inc_i & ~dec_ok)
        cnt_r <= cnt_r + cnt_width_p'(1);
      else if (~inc_i & dec_ok)
        cnt_r <= cnt_r - cnt_width_p'(1);
    end
  end

endmodule

// File: rtl/bsg_blackparrot_mc_link_scheduler.sv
// Spreads one BP request stream over num_links_p manycore fwd links with per-link credits,
// round-robin selection, enable mask and drain fence. BSG_BP_MC_SCHED_PERF_EN adds perf counters.
module bsg_blackparrot_mc_link_scheduler
  import bsg_blackparrot_pkg::*;
#(
  parameter int width_p     = 32,
  parameter int num_links_p = bp_mc_num_links_gp,
  parameter int max_out_p   = 8,
  localparam int cnt_width_lp = $clog2(max_out_p + 1)
) (
  input  logic                                clk_i,
  input  logic                                reset_i,
  input  logic                                req_v_i,
  input  logic [width_p-1:0]                  req_data_i,
  output logic                                req_yumi_o,
  output logic [num_links_p-1:0]              link_v_o,
  output logic [width_p-1:0]                  link_data_o,
  input  logic [num_links_p-1:0]              link_ready_i,
  input  logic [num_links_p-1:0]              credit_i,
  input  logic [num_links_p-1:0]              link_en_i,
  input  logic                                fence_v_i,
  output logic                                fence_done_o,
  output logic [num_links_p*cnt_width_lp-1:0] cnt_o,
`ifdef BSG_BP_MC_SCHED_PERF_EN
  output logic [31:0]                         stall_cnt_o,
  output logic [num_links_p-1:0][31:0]        sent_cnt_o,
`endif
  output logic                                err_o
);

  localparam int ptr_width_lp = (num_links_p > 1) ? $clog2(num_links_p) : 1;

  bp_mc_sched_state_e        state_r;
  logic                      fence_arm_r;
  logic                      hold_v_r;
  logic [width_p-1:0]        hold_data_r;
  logic [num_links_p-1:0]    hold_sel_r;
  logic [ptr_width_lp-1:0]   ptr_r;

  logic [num_links_p-1:0]    eligible, cnt_max, cnt_zero, cnt_err, sel_oh;
  logic [ptr_width_lp-1:0]   sel_idx;
  logic                      sel_found, send_v;

  function automatic logic [ptr_width_lp-1:0] wrap_inc(input logic [ptr_width_lp-1:0] base,
                                                       input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= num_links_p)
      sum = sum - num_links_p;
    return ptr_width_lp'(sum);
  endfunction

  assign link_v_o     = hold_sel_r & {num_links_p{hold_v_r}};
  assign link_data_o  = hold_data_r;
  assign send_v       = |(link_v_o & link_ready_i);
  assign eligible     = link_en_i & ~cnt_max;
  assign fence_done_o = (state_r == e_done);
  assign err_o        = |cnt_err;

  // Acceptance is gated by reset so nothing is taken while the block is held in reset.
  assign req_yumi_o = req_v_i & ~reset_i & (state_r == e_run) & sel_found & (~hold_v_r | send_v);

  // Rotate-priority pick: first eligible link at or after the pointer, wrapping.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sel_oh    = '0;
    for (int k = 0; k < num_links_p; k++) begin
      if (!sel_found && eligible[wrap_inc(ptr_r, k)]) begin
        sel_found = 1'b1;
        sel_idx   = wrap_inc(ptr_r, k);
      end
    end
    if (sel_found)
      sel_oh[sel_idx] = 1'b1;
  end

  for (genvar gi = 0; gi < num_links_p; gi++) begin : g_link
    bsg_blackparrot_mc_credit_counter #(
      .max_out_p  (max_out_p),
      .cnt_width_p(cnt_width_lp)
    ) u_cnt (
      .clk_i  (clk_i),
      .reset_i(reset_i),
      .inc_i  (req_yumi_o & sel_oh[gi]),
      .dec_i  (credit_i[gi]),
      .cnt_o  (cnt_o[gi*cnt_width_lp +: cnt_width_lp]),
      .max_o  (cnt_max[gi]),
      .zero_o (cnt_zero[gi]),
      .err_o  (cnt_err[gi])
    );
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_v_r    <= 1'b0;
      hold_data_r <= '0;
      hold_sel_r  <= '0;
      ptr_r       <= '0;
    end else if (req_yumi_o) begin
      hold_v_r    <= 1'b1;
      hold_data_r <= req_data_i;
      hold_sel_r  <= sel_oh;
      ptr_r       <= wrap_inc(sel_idx, 1);
    end else if (send_v) begin
      hold_v_r    <= 1'b0;
    end
  end

  // The fence re-arms only after fence_v_i has been seen low, so a level held through DONE is inert.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r     <= e_run;
      fence_arm_r <= 1'b1;
    end else begin
      if (!fence_v_i)
        fence_arm_r <= 1'b1;
      else if (state_r == e_run && fence_arm_r)
        fence_arm_r <= 1'b0;
      case (state_r)
        e_run:   if (fence_v_i && fence_arm_r) state_r <= e_drain;
        e_drain: if (!hold_v_r && (&cnt_zero)) state_r <= e_done;
        e_done:  state_r <= e_run;
        default: state_r <= e_run;
      endcase
    end
  end

`ifdef BSG_BP_MC_SCHED_PERF_EN
  logic [31:0] stall_cnt_r;
  assign stall_cnt_o = stall_cnt_r;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)
      stall_cnt_r <= '0;
    else if (req_v_i && !req_yumi_o && state_r == e_run && stall_cnt_r != '1)
      stall_cnt_r <= stall_cnt_r + 32'd1;
  end

  for (genvar gi = 0; gi < num_links_p; gi++) begin : g_perf
    logic [31:0] sent_r;
    assign sent_cnt_o[gi] = sent_r;
    always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i)
        sent_r <= '0;
      else if (link_v_o[gi] && link_ready_i[gi] && sent_r != '1)
        sent_r <= sent_r + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_bsg_blackparrot_mc_link_scheduler.sv
// Self-checking bench: a cycle model of the scheduling rules checked every negedge, plus directed
// scenarios with literal expectations. Define BSG_BP_MC_SCHED_PERF_EN to also cover perf counters.
module tb_bsg_blackparrot_mc_link_scheduler;

  localparam int W   = 16;
  localparam int N   = 3;
  localparam int MAX = 8;
  localparam int CW  = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_v;
  logic [W-1:0]    req_data;
  logic            req_yumi;
  logic [N-1:0]    link_v;
  logic [W-1:0]    link_data;
  logic [N-1:0]    link_ready, credit, link_en;
  logic            fence_v, fence_done, err;
  logic [N*CW-1:0] cnt;
`ifdef BSG_BP_MC_SCHED_PERF_EN
  logic [31:0]        stall_cnt;
  logic [N-1:0][31:0] sent_cnt;
`endif

  int checks = 0;
  int errors = 0;

  bsg_blackparrot_mc_link_scheduler #(.width_p(W), .num_links_p(N), .max_out_p(MAX)) dut (
    .clk_i       (clk),
    .reset_i     (rst),
    .req_v_i     (req_v),
    .req_data_i  (req_data),
    .req_yumi_o  (req_yumi),
    .link_v_o    (link_v),
    .link_data_o (link_data),
    .link_ready_i(link_ready),
    .credit_i    (credit),
    .link_en_i   (link_en),
    .fence_v_i   (fence_v),
    .fence_done_o(fence_done),
    .cnt_o       (cnt),
`ifdef BSG_BP_MC_SCHED_PERF_EN
    .stall_cnt_o (stall_cnt),
    .sent_cnt_o  (sent_cnt),
`endif
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_cnt[N];
  bit         m_hold_v;
  int         m_hold_idx;
  logic [W-1:0] m_hold_data;
  int         m_ptr;
  int         m_state;  // 0 run, 1 drain, 2 done
  bit         m_err, m_arm;

  task automatic model_reset();
    for (int i = 0; i < N; i++) m_cnt[i] = 0;
    m_hold_v = 0; m_hold_idx = 0; m_hold_data = '0;
    m_ptr = 0; m_state = 0; m_err = 0; m_arm = 1;
  endtask

  always @(negedge clk) begin : model
    bit [N-1:0]    elig;
    bit [N-1:0]    exp_lv;
    logic [N*CW-1:0] exp_cnt;
    bit            snd, yum, drained;
    int            sel, dec;
    if (rst) begin
      model_reset();
      check("rst_yumi", req_yumi, 0);
      check("rst_link_v", link_v, 0);
      check("rst_data", link_data, 0);
      check("rst_cnt", cnt, 0);
      check("rst_done_err", {fence_done, err}, 0);
    end else begin
      for (int i = 0; i < N; i++) elig[i] = link_en[i] && (m_cnt[i] < MAX);
      snd = m_hold_v && link_ready[m_hold_idx];
      sel = -1;
      for (int k = 0; k < N; k++)
        if (sel < 0 && elig[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
      yum = req_v && (m_state == 0) && (sel >= 0) && (!m_hold_v || snd);
      exp_lv = '0;
      if (m_hold_v) exp_lv[m_hold_idx] = 1'b1;
      exp_cnt = '0;
      for (int i = 0; i < N; i++) exp_cnt[i*CW +: CW] = CW'(m_cnt[i]);

      check("m_yumi", req_yumi, yum);
      check("m_link_v", link_v, exp_lv);
      check("m_data", link_data, m_hold_data);
      check("m_cnt", cnt, exp_cnt);
      check("m_done", fence_done, m_state == 2);
      check("m_err", err, m_err);

      drained = !m_hold_v;
      for (int i = 0; i < N; i++) if (m_cnt[i] != 0) drained = 0;

      for (int i = 0; i < N; i++) begin
        dec = credit[i] ? 1 : 0;
        if (dec == 1 && m_cnt[i] == 0) begin m_err = 1; dec = 0; end
        m_cnt[i] = m_cnt[i] + ((yum && sel == i) ? 1 : 0) - dec;
      end
      if (yum) begin
        m_hold_v = 1; m_hold_idx = sel; m_hold_data = req_data; m_ptr = (sel + 1) % N;
      end else if (snd) begin
        m_hold_v = 0;
      end
      case (m_state)
        0: if (fence_v && m_arm) begin m_state = 1; m_arm = 0; end
        1: if (drained) m_state = 2;
        default: m_state = 0;
      endcase
      if (!fence_v) m_arm = 1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample_tick(inout int n);
    @(negedge clk);
    if (req_yumi) n++;
    @(posedge clk);
    #1;
  endtask

  task automatic drain_credits();
    for (int c = 0; c < 12; c++) begin
      credit = '0;
      for (int i = 0; i < N; i++) if (m_cnt[i] > 0) credit[i] = 1'b1;
      tick();
    end
    credit = '0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int lat;
    rst = 1; req_v = 0; req_data = '0; link_ready = '1; credit = '0; link_en = '1; fence_v = 0;
    repeat (3) tick();
    check("reset_link_v", link_v, 0);
    check("reset_cnt", cnt, 0);
    check("reset_flags", {req_yumi, fence_done, err}, 0);
    rst = 0;
    tick();

    // 1: round robin over three enabled links
    for (int k = 0; k < 6; k++) begin
      req_v = 1; req_data = W'(16'h100 + k);
      tick();
      check("t1_grant", link_v, 3'b001 << (k % 3));
      check("t1_data", link_data, 16'h100 + k);
      $display("t1 req %0d -> link_v %b data %h", k, link_v, link_data);
    end
    req_v = 0;
    tick();
    check("t1_cnt", cnt, 12'h222);
    check("t1_idle", link_v, 0);
    credit = '1; tick(); tick(); credit = '0;

    // 2: single link saturates at MAX, one credit admits exactly one more
    link_en = 3'b001; req_v = 1; n = 0;
    repeat (10) sample_tick(n);
    check("t2_accepts", n, 8);
    check("t2_cnt0", cnt[3:0], 8);
    check("t2_stalled", req_yumi, 0);
    $display("t2 accepted %0d cnt0 %0d", n, cnt[3:0]);
    credit = 3'b001; n = 0;
    sample_tick(n);
    credit = '0;
    repeat (4) sample_tick(n);
    check("t2_extra", n, 1);
    req_v = 0;
    drain_credits();
    link_en = '1;

    // 3: held packet blocked by link 1 backpressure
    link_ready = 3'b101; req_v = 1; req_data = 16'h300;
    tick();
    req_data = 16'h301;
    for (int k = 0; k < 3; k++) begin
      check("t3_hold", link_v, 3'b010);
      check("t3_block", req_yumi, 0);
      $display("t3 blocked cycle %0d link_v %b", k, link_v);
      tick();
    end
    link_ready = '1;
    #1;
    check("t3_resume", req_yumi, 1);
    tick();
    req_v = 0;
    tick();
    drain_credits();

    // 4: fence with cnt=(1,2,0) and a packet held
    link_en = 3'b010; req_v = 1;
    tick(); tick();
    req_v = 0;
    tick();
    link_en = 3'b001; link_ready = '0; req_v = 1; req_data = 16'h400;
    tick();
    check("t4_setup_cnt", cnt, 12'h021);
    fence_v = 1; link_en = '1;
    repeat (3) begin
      tick();
      check("t4_no_accept", req_yumi, 0);
    end
    link_ready = '1;
    tick();
    check("t4_sent", link_v, 0);
    credit = 3'b001; tick();
    credit = 3'b010; tick(); tick();
    credit = '0;
    check("t4_not_yet", fence_done, 0);
    lat = -1;
    for (int c = 1; c <= 10 && lat < 0; c++) begin
      tick();
      if (fence_done) lat = c;
    end
    check("t4_done_latency", lat, 1);
    $display("t4 fence_done after %0d cycles", lat);
    tick();
    check("t4_pulse_width", fence_done, 0);
    check("t4_run_resumes", req_yumi, 1);
    tick();
    fence_v = 0; req_v = 0;
    tick();
    drain_credits();

    // 5: simultaneous reserve and credit, then underflow credit
    link_en = 3'b100; req_v = 1;
    repeat (4) tick();
    check("t5_cnt2_pre", cnt[11:8], 4);
    credit = 3'b100;
    tick();
    credit = '0; req_v = 0;
    check("t5_cnt2_same", cnt[11:8], 4);
    tick();
    credit = 3'b001;
    tick();
    credit = '0;
    check("t5_err", err, 1);
    check("t5_cnt0", cnt[3:0], 0);
    $display("t5 cnt2 %0d err %0d", cnt[11:8], err);
    drain_credits();

    // 6: asynchronous reset between clock edges
    link_en = '1; link_ready = '0; req_v = 1;
    tick(); tick();
    check("t6_pre_link_v", link_v != 0, 1);
    #2;
    rst = 1;
    #1;
    check("t6_async_link_v", link_v, 0);
    check("t6_async_cnt", cnt, 0);
    check("t6_async_done_err", {fence_done, err}, 0);
    $display("t6 async reset link_v %b cnt %h", link_v, cnt);
    tick(); tick();
    rst = 0; link_en = '0; req_v = 1;
    repeat (5) tick();
    req_v = 0;
`ifdef BSG_BP_MC_SCHED_PERF_EN
    check("t6_stall_cnt", stall_cnt, 5);
    check("t6_sent_cnt", sent_cnt[0], 0);
    $display("t6 stall_cnt %0d", stall_cnt);
`endif
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
